// File: rtl/nios_ii_timer_pkg.sv
// Shared definitions for the interval-timer Avalon-MM driver: register map,
// register bit positions and the driver FSM state encoding.
package nios_ii_timer_pkg;

  // Timer slave word offsets
  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CONTROL = 3'd1;
  localparam logic [2:0] REG_PERL    = 3'd2;
  localparam logic [2:0] REG_PERH    = 3'd3;
  localparam logic [2:0] REG_SNAPL   = 3'd4;
  localparam logic [2:0] REG_SNAPH   = 3'd5;

  // STATUS bits
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  // CONTROL bits
  localparam int CT_ITO   = 0;
  localparam int CT_CONT  = 1;
  localparam int CT_START = 2;
  localparam int CT_STOP  = 3;

  localparam logic [15:0] CTRL_STOP = 16'h0008;

  typedef enum logic [4:0] {
    S_IDLE,
    S_WR_STOP,
    S_WR_PERL,
    S_WR_PERH,
    S_WR_CLR,
    S_WR_CTRL,
    S_RUN,
    S_POLL_RD,
    S_POLL_WAIT,
    S_ACK_CLR,
    S_SNAP_WR,
    S_SNAP_RDL,
    S_SNAP_WTL,
    S_SNAP_RDH,
    S_SNAP_WTH,
    S_STOP_WR
  } state_e;

endpackage

// File: rtl/nios_ii_timer_driver.sv
// Avalon-MM master that programs an interval timer, services its timeouts
// (by IRQ or by polling STATUS), emits a tick per timeout and captures
// counter snapshots. Each FSM state performs at most one bus access; the bus
// outputs are decoded from the current state.
module nios_ii_timer_driver
  import nios_ii_timer_pkg::*;
#(
  parameter int POLL_INTERVAL = 256,
  parameter int TICK_CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_start,
  input  logic [31:0]           cfg_period,
  input  logic                  cfg_continuous,
  input  logic                  cfg_irq_en,
  input  logic                  stop_req,
  input  logic                  snap_req,
  output logic                  busy,
  output logic                  running,
  output logic                  tick,
  output logic [TICK_CNT_W-1:0] tick_count,
  output logic                  snap_valid,
  output logic [31:0]           snap_value,
  output logic [2:0]            av_address,
  output logic                  av_chipselect,
  output logic                  av_write_n,
  output logic [15:0]           av_writedata,
  input  logic [15:0]           av_readdata,
  input  logic                  av_irq
);

  localparam int              PC_W        = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [PC_W-1:0] POLL_RELOAD = PC_W'(POLL_INTERVAL - 1);

  state_e                  state_q, state_d;
  logic [31:0]             period_q, period_d;
  logic                    cont_q, cont_d;
  logic                    ito_q, ito_d;
  logic [TICK_CNT_W-1:0]   tick_count_q, tick_count_d;
  logic [PC_W-1:0]         poll_cnt_q, poll_cnt_d;
  logic [31:0]             snap_value_q, snap_value_d;
  logic                    snap_valid_q, snap_valid_d;
  logic                    take_start;
  logic                    service;

  // cfg_start is only honoured when no bus sequence is in flight
  assign take_start = cfg_start && (state_q == S_IDLE || state_q == S_RUN);
  // Timeout pending: IRQ level in interrupt mode, poll counter expiry otherwise
  assign service    = ito_q ? av_irq : (poll_cnt_q == '0);

  // Next-state, bus decode and per-state side effects
  always_comb begin
    state_d       = state_q;
    period_d      = period_q;
    cont_d        = cont_q;
    ito_d         = ito_q;
    tick_count_d  = tick_count_q;
    poll_cnt_d    = POLL_RELOAD;
    snap_value_d  = snap_value_q;
    snap_valid_d  = 1'b0;
    tick          = 1'b0;
    av_address    = 3'd0;
    av_chipselect = 1'b0;
    av_write_n    = 1'b1;
    av_writedata  = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) state_d = S_WR_STOP;
      end
      S_WR_STOP: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_CONTROL;
        av_writedata  = CTRL_STOP;
        state_d       = S_WR_PERL;
      end
      S_WR_PERL: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_PERL;
        av_writedata  = period_q[15:0];
        state_d       = S_WR_PERH;
      end
      S_WR_PERH: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_PERH;
        av_writedata  = period_q[31:16];
        state_d       = S_WR_CLR;
      end
      S_WR_CLR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_STATUS;
        state_d       = S_WR_CTRL;
      end
      S_WR_CTRL: begin
        av_chipselect          = 1'b1;
        av_write_n             = 1'b0;
        av_address             = REG_CONTROL;
        av_writedata[CT_START] = 1'b1;
        av_writedata[CT_CONT]  = cont_q;
        av_writedata[CT_ITO]   = ito_q;
        state_d                = S_RUN;
      end
      S_RUN: begin
        // Counter only runs in polling mode; any exit from RUN reloads it
        poll_cnt_d = ito_q ? POLL_RELOAD : poll_cnt_q - 1'b1;
        if (cfg_start)     state_d = S_WR_STOP;
        else if (stop_req) state_d = S_STOP_WR;
        else if (service)  state_d = ito_q ? S_ACK_CLR : S_POLL_RD;
        else if (snap_req) state_d = S_SNAP_WR;
      end
      S_POLL_RD: begin
        av_chipselect = 1'b1;
        av_address    = REG_STATUS;
        state_d       = S_POLL_WAIT;
      end
      S_POLL_WAIT: begin
        state_d = av_readdata[ST_TO] ? S_ACK_CLR : S_RUN;
      end
      S_ACK_CLR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_STATUS;
        tick          = 1'b1;
        tick_count_d  = tick_count_q + 1'b1;
        state_d       = cont_q ? S_RUN : S_IDLE;
      end
      S_SNAP_WR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_SNAPL;
        state_d       = S_SNAP_RDL;
      end
      S_SNAP_RDL: begin
        av_chipselect = 1'b1;
        av_address    = REG_SNAPL;
        state_d       = S_SNAP_WTL;
      end
      S_SNAP_WTL: begin
        snap_value_d[15:0] = av_readdata;
        state_d            = S_SNAP_RDH;
      end
      S_SNAP_RDH: begin
        av_chipselect = 1'b1;
        av_address    = REG_SNAPH;
        state_d       = S_SNAP_WTH;
      end
      S_SNAP_WTH: begin
        snap_value_d[31:16] = av_readdata;
        snap_valid_d        = 1'b1;
        state_d             = S_RUN;
      end
      S_STOP_WR: begin
        av_chipselect = 1'b1;
        av_write_n    = 1'b0;
        av_address    = REG_CONTROL;
        av_writedata  = CTRL_STOP;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take_start) begin
      period_d     = cfg_period;
      cont_d       = cfg_continuous;
      ito_d        = cfg_irq_en;
      tick_count_d = '0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      period_q     <= '0;
      cont_q       <= 1'b0;
      ito_q        <= 1'b0;
      tick_count_q <= '0;
      poll_cnt_q   <= POLL_RELOAD;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      cont_q       <= cont_d;
      ito_q        <= ito_d;
      tick_count_q <= tick_count_d;
      poll_cnt_q   <= poll_cnt_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
    end
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_RUN);
  assign running    = (state_q == S_RUN);
  assign tick_count = tick_count_q;
  assign snap_value = snap_value_q;
  assign snap_valid = snap_valid_q;

endmodule
